// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated single-port memory responding to CPU rd/wr request levels
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - synchronous active-high reset (memory contents are preserved)
//   addr     - word address, sampled when a request is accepted
//   rd, wr   - request levels; exactly one high in IDLE starts an access
//   data_in  - write data, sampled when a write is accepted
//   data_out - read data register, updated only by completed reads
//   ready    - one-cycle pulse when an access completes
//   busy     - high while an accepted access is in WAIT or DONE
//   err      - one-cycle pulse when rd and wr are both high in IDLE
module mem_responder #(
    parameter int AWIDTH      = 5,
    parameter int DWIDTH      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    // Left uninitialised on purpose; contents survive reset.
    logic [DWIDTH-1:0] mem [2**AWIDTH];

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic              is_wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            data_out <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            is_wr_q  <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rd && wr) begin
                        // Illegal request: flag it and wait for both levels to drop.
                        err   <= 1'b1;
                        state <= S_HOLD;
                    end else if (rd || wr) begin
                        addr_q   <= addr;
                        is_wr_q  <= wr;
                        wdata_q  <= data_in;
                        wait_cnt <= WAIT_LOAD;
                        busy     <= 1'b1;
                        state    <= (WAIT_LOAD == 4'd0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Reaching DONE when the count hits zero lands on edge k+WAIT_CYCLES.
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!is_wr_q) begin
                        data_out <= mem[addr_q];
                    end
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    // A request level held past completion must not start a second access.
                    if (!rd && !wr) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write commits on the edge leaving DONE; a reset on that edge suppresses it.
    always_ff @(posedge clk) begin
        if (!rst && state == S_DONE && is_wr_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] addr;
    logic       rd, wr, rd0, wr0;
    logic [7:0] data_in;
    logic [7:0] data_out, data_out0;
    logic       ready, busy, err, ready0, busy0, err0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
        .data_out(data_out), .ready(ready), .busy(busy), .err(err)
    );

    mem_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .addr(addr), .rd(rd0), .wr(wr0), .data_in(data_in),
        .data_out(data_out0), .ready(ready0), .busy(busy0), .err(err0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd = 0; wr = 0; rd0 = 0; wr0 = 0; addr = 0; data_in = 0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        checks++; if ({ready, busy, err} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {ready, busy, err}); end
        checks++; if (dut.state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", dut.state); end
        checks++; if (dut.wait_cnt !== 4'd0) begin failures++; $display("FAIL reset_wait_cnt: got %0d expected 0", dut.wait_cnt); end
    endtask

    task automatic test_read();
        dut.mem[3] <= 8'hA5;
        rd = 1; addr = 5'd3;
        tick(); // edge k
        rd = 0; addr = 5'd9;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL read_busy_k: got %b expected 1", busy); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL read_ready_k: got %b expected 0", ready); end
        tick(); // k+1
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL read_ready_k1: got %b expected 0", ready); end
        tick(); // k+2
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL read_ready_k2: got %b expected 1", ready); end
        checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL read_data: got %h expected a5", data_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL read_busy_k2: got %b expected 0", busy); end
        tick(); // k+3
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL read_ready_k3: got %b expected 0", ready); end
        checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL read_data_hold: got %h expected a5", data_out); end
    endtask

    task automatic test_write();
        wr = 1; addr = 5'd7; data_in = 8'h3C;
        tick(); // k
        wr = 0; data_in = 8'hFF; addr = 5'd0;
        tick(); tick(); // k+2 completes
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL write_ready: got %b expected 1", ready); end
        checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL write_keeps_data_out: got %h expected a5", data_out); end
        tick();
        checks++; if (dut.mem[7] !== 8'h3C) begin failures++; $display("FAIL write_mem7: got %h expected 3c", dut.mem[7]); end
        rd = 1; addr = 5'd7;
        tick();
        rd = 0;
        tick(); tick();
        checks++; if (data_out !== 8'h3C) begin failures++; $display("FAIL readback_7: got %h expected 3c", data_out); end
        tick();
        // Top address is a valid location.
        wr = 1; addr = 5'd31; data_in = 8'hC3;
        tick(); wr = 0; tick(); tick(); tick();
        rd = 1; tick(); rd = 0; tick(); tick();
        checks++; if (data_out !== 8'hC3) begin failures++; $display("FAIL readback_31: got %h expected c3", data_out); end
        tick();
    endtask

    task automatic test_held();
        int pulses = 0;
        dut.mem[2] <= 8'h77;
        rd = 1; addr = 5'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ready === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL held_pulses: got %0d expected 1", pulses); end
        checks++; if (dut.state !== 2'd3) begin failures++; $display("FAIL held_in_hold: got %0d expected 3", dut.state); end
        checks++; if (data_out !== 8'h77) begin failures++; $display("FAIL held_data: got %h expected 77", data_out); end
        rd = 0;
        tick();
        checks++; if (dut.state !== 2'd0) begin failures++; $display("FAIL held_release_idle: got %0d expected 0", dut.state); end
    endtask

    task automatic test_illegal();
        int rdy = 0;
        rd = 1; wr = 1; addr = 5'd2; data_in = 8'h00;
        tick();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL illegal_err: got %b expected 1", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL illegal_busy: got %b expected 0", busy); end
        if (ready === 1'b1) rdy++;
        rd = 0; wr = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ready === 1'b1) rdy++;
            if (i == 0) begin
                checks++; if (err !== 1'b0) begin failures++; $display("FAIL illegal_err_one_cycle: got %b expected 0", err); end
            end
        end
        checks++; if (rdy !== 0) begin failures++; $display("FAIL illegal_ready: got %0d pulses expected 0", rdy); end
        checks++; if (dut.mem[2] !== 8'h77) begin failures++; $display("FAIL illegal_mem: got %h expected 77", dut.mem[2]); end
        checks++; if (data_out !== 8'h77) begin failures++; $display("FAIL illegal_data_out: got %h expected 77", data_out); end
    endtask

    task automatic test_reset_mid();
        dut.mem[4] <= 8'h22;
        wr = 1; addr = 5'd4; data_in = 8'h11;
        tick(); // k
        wr = 0; rst = 1;
        tick(); // k+1 under reset
        rst = 0;
        checks++; if ({ready, busy, err} !== 3'b000) begin failures++; $display("FAIL rstwr_flags: got %b expected 000", {ready, busy, err}); end
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rstwr_data_out: got %h expected 00", data_out); end
        // First edge out of reset accepts a read.
        rd = 1; addr = 5'd4;
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL post_reset_accept: got %b expected 1", busy); end
        checks++; if (dut.mem[4] !== 8'h22) begin failures++; $display("FAIL rstwr_mem: got %h expected 22", dut.mem[4]); end
        rd = 0;
        tick(); tick();
        checks++; if (data_out !== 8'h22) begin failures++; $display("FAIL rstwr_readback: got %h expected 22", data_out); end
        tick();
        // Aborted read leaves data_out cleared.
        rd = 1; addr = 5'd2;
        tick(); rd = 0; rst = 1;
        tick(); rst = 0;
        tick(); tick();
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rstrd_data_out: got %h expected 00", data_out); end
    endtask

    task automatic test_zero_wait();
        dut0.mem[0] <= 8'h5A;
        rd0 = 1; addr = 5'd0;
        tick(); // k
        rd0 = 0;
        checks++; if (busy0 !== 1'b1 || ready0 !== 1'b0) begin failures++; $display("FAIL zw_k: got busy=%b ready=%b expected busy=1 ready=0", busy0, ready0); end
        tick(); // k+1
        checks++; if (ready0 !== 1'b1) begin failures++; $display("FAIL zw_ready: got %b expected 1", ready0); end
        checks++; if (data_out0 !== 8'h5A) begin failures++; $display("FAIL zw_data: got %h expected 5a", data_out0); end
        tick();
        checks++; if (ready0 !== 1'b0) begin failures++; $display("FAIL zw_ready_drop: got %b expected 0", ready0); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_held();
        test_illegal();
        test_reset_mid();
        test_zero_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
